// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds PC/nPC, reads one instruction word per fetch_go via the RAM/MFC handshake, loads the IR.
// Latency 3+ cycles from fetch_go to IR_Enable; fetch_go is ignored while busy; FAULT is left only by Clr.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned MFC_TIMEOUT  = 15,
   parameter logic [5:0]  LOAD_WORD_OP = 6'b000000
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic        fetch_go,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   input  logic [31:0] RAM_DataOut,
   input  logic        MFC,
   output logic [31:0] RAM_Address,
   output logic        RAM_enable,
   output logic [5:0]  RAM_OpCode,
   output logic [31:0] IR_In,
   output logic        IR_Enable,
   output logic [31:0] PC_out,
   output logic [31:0] nPC_out,
   output logic        busy,
   output logic        fetch_fault,
   output logic [1:0]  fault_code
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_LOAD  = 3'd3;
   localparam logic [2:0] S_FAULT = 3'd4;

   localparam logic [7:0] TMO = 8'(MFC_TIMEOUT);

   logic [2:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_npc;
   logic [31:0] r_tgt;
   logic        r_pend;
   logic [7:0]  r_cnt;
   logic [31:0] r_ir;
   logic        r_ir_en;
   logic        r_ram_en;
   logic [5:0]  r_opcode;
   logic        r_fault;
   logic [1:0]  r_code;

   logic [7:0]  w_cnt_nxt;
   logic [31:0] w_npc_adv;

   assign w_cnt_nxt = r_cnt + 8'd1;

   // A redirect arriving in the LOAD cycle itself wins over any older pending target.
   assign w_npc_adv = redirect ? redirect_addr :
                      r_pend   ? r_tgt         :
                                 r_npc + 32'd4;

   always_ff @(posedge Clk) begin
      if (!Clr) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_npc    <= RESET_PC + 32'd4;
         r_tgt    <= 32'd0;
         r_pend   <= 1'b0;
         r_cnt    <= 8'd0;
         r_ir     <= 32'd0;
         r_ir_en  <= 1'b0;
         r_ram_en <= 1'b0;
         r_opcode <= 6'd0;
         r_fault  <= 1'b0;
         r_code   <= 2'b00;
      end else begin
         r_ir_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fetch_go) begin
                  if (r_pc[1:0] != 2'b00) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                     r_code  <= 2'b01;
                  end else begin
                     r_state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               r_cnt    <= 8'd0;
               r_ram_en <= 1'b1;
               r_opcode <= LOAD_WORD_OP;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               if (MFC) begin
                  r_ir     <= RAM_DataOut;
                  r_ram_en <= 1'b0;
                  r_opcode <= 6'd0;
                  r_state  <= S_LOAD;
               end else if (w_cnt_nxt == TMO) begin
                  r_ram_en <= 1'b0;
                  r_opcode <= 6'd0;
                  r_fault  <= 1'b1;
                  r_code   <= 2'b10;
                  r_state  <= S_FAULT;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            S_LOAD: begin
               r_ir_en <= 1'b1;
               r_pc    <= r_npc;
               r_npc   <= w_npc_adv;
               r_state <= S_IDLE;
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (r_state == S_LOAD) begin
            r_pend <= 1'b0;
         end else if (redirect && (r_state != S_FAULT)) begin
            r_pend <= 1'b1;
            r_tgt  <= redirect_addr;
         end
      end
   end

   assign RAM_Address = r_pc;
   assign RAM_enable  = r_ram_en;
   assign RAM_OpCode  = r_opcode;
   assign IR_In       = r_ir;
   assign IR_Enable   = r_ir_en;
   assign PC_out      = r_pc;
   assign nPC_out     = r_npc;
   assign busy        = (r_state != S_IDLE);
   assign fetch_fault = r_fault;
   assign fault_code  = r_code;

endmodule
